schmidl_cox_sync_controller: RTL and testbench

Frame-synchronisation controller for the Schmidl-Cox receive chain. It consumes the averaged metric stream and the latency-matched sample stream from the metric calculator in lockstep. It searches for a metric peak above a programmable threshold, then gates exactly `FFT_SIZE` samples per OFDM symbol to the downstream FFT, skipping each cyclic prefix, for a programmed number of symbols. It then re-arms the search.

---
 rtl/schmidl_cox_pkg.sv | 24 ++
 rtl/sc_peak_tracker.sv | 73 +++++++
 rtl/schmidl_cox_sync_controller.sv | 199 +++++++++++++++++++
 tb/tb_schmidl_cox_sync_controller.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/schmidl_cox_pkg.sv
// Shared definitions for the Schmidl-Cox receive chain: controller state
// encoding and counter-width helpers. The metric calculator uses this package too.
package schmidl_cox_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_PEAK,
      ST_SKIP,
      ST_OUTPUT
   } sc_state_e;

   localparam int SYM_CNT_WIDTH = 8;

   // Width of since_max / skip_cnt. It must hold any count up to FFT_SIZE + CP_SIZE.
   function automatic int cnt_width(input int fft_size, input int cp_size);
      return $clog2(fft_size + cp_size + 1);
   endfunction

   // Width of the per-symbol emit counter. It wraps at fft_size - 1.
   function automatic int emit_width(input int fft_size);
      return (fft_size > 1) ? $clog2(fft_size) : 1;
   endfunction

endpackage

// File: rtl/sc_peak_tracker.sv
// Tracks the running metric maximum after a threshold crossing. It raises
// confirm on the transfer that completes CP_SIZE pairs with no larger metric.
module sc_peak_tracker
   import schmidl_cox_pkg::*;
#(
   parameter int METRIC_WIDTH = 40,
   parameter int CP_SIZE      = 128,
   parameter int CNT_WIDTH    = 11
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    fire,
   input  logic [METRIC_WIDTH-1:0] metric,
   input  logic                    start,
   output logic                    confirm,
   output logic [METRIC_WIDTH-1:0] max_value
);

   localparam logic [CNT_WIDTH-1:0] CONFIRM_AT = CNT_WIDTH'(CP_SIZE - 1);

   logic                    armed_q, armed_d;
   logic [METRIC_WIDTH-1:0] max_q, max_d;
   logic [CNT_WIDTH-1:0]    since_max_q, since_max_d;
   logic                    greater;
   logic                    hit;

   // A strictly larger metric restarts the window. Ties age the current maximum.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      armed_d     = armed_q;
      max_d       = max_q;
      since_max_d = since_max_q;
      greater     = metric > max_q;
      hit         = armed_q & fire & ~greater & (since_max_q == CONFIRM_AT);
      if (clear) begin
         armed_d     = 1'b0;
         max_d       = '0;
         since_max_d = '0;
      end else if (start) begin
         armed_d     = 1'b1;
         max_d       = metric;
         since_max_d = '0;
      end else if (armed_q & fire) begin
         if (greater) begin
            max_d       = metric;
            since_max_d = '0;
         end else if (hit) begin
            armed_d     = 1'b0;
            since_max_d = '0;
         end else begin
            since_max_d = since_max_q + 1'b1;
         end
      end
   end

   // Tracker registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed_q     <= 1'b0;
         max_q       <= '0;
         since_max_q <= '0;
      end else begin
         armed_q     <= armed_d;
         max_q       <= max_d;
         since_max_q <= since_max_d;
      end
   end

   assign confirm   = hit;
   assign max_value = max_q;

endmodule

// File: rtl/schmidl_cox_sync_controller.sv
// Frame-sync controller. It finds a confirmed metric peak, then forwards FFT_SIZE
// samples per symbol and skips each cyclic prefix, for num_symbols symbols.
module schmidl_cox_sync_controller
   import schmidl_cox_pkg::*;
#(
   parameter int FFT_SIZE     = 1024,
   parameter int CP_SIZE      = 128,
   parameter int METRIC_WIDTH = 32 + $clog2(CP_SIZE + 1),
   parameter int START_OFFSET = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic [METRIC_WIDTH-1:0] threshold,
   input  logic [7:0]              num_symbols,
   input  logic [METRIC_WIDTH-1:0] m_tdata,
   input  logic                    m_tvalid,
   output logic                    m_tready,
   input  logic                    m_tlast,
   input  logic [31:0]             s_tdata,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   input  logic                    s_tlast,
   output logic [31:0]             o_tdata,
   output logic                    o_tlast,
   output logic                    o_tvalid,
   input  logic                    o_tready,
   output logic                    detect,
   output logic [METRIC_WIDTH-1:0] peak_value,
   output logic                    busy
);

   localparam int CNT_WIDTH  = cnt_width(FFT_SIZE, CP_SIZE);
   localparam int EMIT_WIDTH = emit_width(FFT_SIZE);
   localparam logic [EMIT_WIDTH-1:0] EMIT_LAST = EMIT_WIDTH'(FFT_SIZE - 1);
   localparam logic [CNT_WIDTH-1:0]  SKIP_START = CNT_WIDTH'(START_OFFSET);
   localparam logic [CNT_WIDTH-1:0]  SKIP_CP    = CNT_WIDTH'(CP_SIZE);

   sc_state_e                  state_q, state_d;
   logic [METRIC_WIDTH-1:0]    threshold_q, threshold_d;
   logic                       thr_valid_q, thr_valid_d;
   logic [CNT_WIDTH-1:0]       skip_cnt_q, skip_cnt_d;
   logic [EMIT_WIDTH-1:0]      emit_cnt_q, emit_cnt_d;
   logic [SYM_CNT_WIDTH-1:0]   sym_cnt_q, sym_cnt_d;
   logic [SYM_CNT_WIDTH-1:0]   num_sym_q, num_sym_d;
   logic                       detect_q, detect_d;
   logic                       busy_q, busy_d;
   logic [METRIC_WIDTH-1:0]    peak_value_q, peak_value_d;

   logic                       emit;
   logic                       path_open;
   logic                       fire;
   logic                       start;
   logic                       confirm;
   logic [METRIC_WIDTH-1:0]    max_value;
   logic [METRIC_WIDTH-1:0]    thr_eff;
   logic                       unused_tlast;

   // The stream framing comes from the metric peak, so the input tlast flags carry no information here.
   assign unused_tlast = m_tlast ^ s_tlast;

   // Join the two input streams and gate them onto the output.
   assign emit      = (state_q == ST_OUTPUT);
   assign path_open = ~emit | o_tready;
   assign fire      = m_tvalid & s_tvalid & path_open;
   assign m_tready  = path_open & s_tvalid;
   assign s_tready  = path_open & m_tvalid;
   assign o_tdata   = s_tdata;
   assign o_tvalid  = emit & m_tvalid & s_tvalid;
   assign o_tlast   = emit & (emit_cnt_q == EMIT_LAST);

   // Until the first SEARCH cycle captures the threshold after reset, the live input is used.
   assign thr_eff = thr_valid_q ? threshold_q : threshold;
   assign start   = (state_q == ST_SEARCH) & fire & (m_tdata > thr_eff) & ~clear;

   sc_peak_tracker #(
      .METRIC_WIDTH (METRIC_WIDTH),
      .CP_SIZE      (CP_SIZE),
      .CNT_WIDTH    (CNT_WIDTH)
   ) u_peak_tracker (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .fire      (fire),
      .metric    (m_tdata),
      .start     (start),
      .confirm   (confirm),
      .max_value (max_value)
   );

   // Next-state logic: clear wins over any transfer, and counters move only on fire.
   always_comb begin
      state_d      = state_q;
      threshold_d  = threshold_q;
      thr_valid_d  = thr_valid_q;
      skip_cnt_d   = skip_cnt_q;
      emit_cnt_d   = emit_cnt_q;
      sym_cnt_d    = sym_cnt_q;
      num_sym_d    = num_sym_q;
      peak_value_d = peak_value_q;
      detect_d     = 1'b0;

      if ((state_q == ST_SEARCH) && !thr_valid_q) begin
         threshold_d = threshold;
         thr_valid_d = 1'b1;
      end

      if (clear) begin
         state_d     = ST_SEARCH;
         threshold_d = threshold;
         thr_valid_d = 1'b1;
         skip_cnt_d  = '0;
         emit_cnt_d  = '0;
         sym_cnt_d   = '0;
      end else if (fire) begin
         unique case (state_q)
            ST_SEARCH: begin
               if (start) state_d = ST_PEAK;
            end
            ST_PEAK: begin
               if (confirm) begin
                  detect_d     = 1'b1;
                  peak_value_d = max_value;
                  num_sym_d    = (num_symbols == 8'd0) ? 8'd1 : num_symbols;
                  sym_cnt_d    = '0;
                  emit_cnt_d   = '0;
                  if (START_OFFSET == 0) begin
                     state_d = ST_OUTPUT;
                  end else begin
                     state_d    = ST_SKIP;
                     skip_cnt_d = SKIP_START;
                  end
               end
            end
            ST_SKIP: begin
               if (skip_cnt_q <= CNT_WIDTH'(1)) begin
                  skip_cnt_d = '0;
                  state_d    = ST_OUTPUT;
               end else begin
                  skip_cnt_d = skip_cnt_q - 1'b1;
               end
            end
            ST_OUTPUT: begin
               emit_cnt_d = emit_cnt_q + 1'b1;
               if (emit_cnt_q == EMIT_LAST) begin
                  emit_cnt_d = '0;
                  sym_cnt_d  = sym_cnt_q + 8'd1;
                  if ((sym_cnt_q + 8'd1) == num_sym_q) begin
                     state_d     = ST_SEARCH;
                     threshold_d = threshold;
                     thr_valid_d = 1'b1;
                  end else if (CP_SIZE == 0) begin
                     state_d = ST_OUTPUT;
                  end else begin
                     state_d    = ST_SKIP;
                     skip_cnt_d = SKIP_CP;
                  end
               end
            end
         endcase
      end

      busy_d = (state_d != ST_SEARCH);
   end

   // Control registers.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: the async reset covers every flop, peak_value included; clear is the synchronous path that leaves peak_value alone.
      if (reset) begin
         state_q      <= ST_SEARCH;
         threshold_q  <= '0;
         thr_valid_q  <= 1'b0;
         skip_cnt_q   <= '0;
         emit_cnt_q   <= '0;
         sym_cnt_q    <= '0;
         num_sym_q    <= '0;
         detect_q     <= 1'b0;
         busy_q       <= 1'b0;
         peak_value_q <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every flop here samples pre-edge values.
         state_q      <= state_d;
         threshold_q  <= threshold_d;
         thr_valid_q  <= thr_valid_d;
         skip_cnt_q   <= skip_cnt_d;
         emit_cnt_q   <= emit_cnt_d;
         sym_cnt_q    <= sym_cnt_d;
         num_sym_q    <= num_sym_d;
         detect_q     <= detect_d;
         busy_q       <= busy_d;
         peak_value_q <= peak_value_d;
      end
   end

   assign detect     = detect_q;
   assign busy       = busy_q;
   assign peak_value = peak_value_q;

endmodule

// File: tb/tb_schmidl_cox_sync_controller.sv
// Self-checking bench for schmidl_cox_sync_controller. A frame-level model
// predicts which input pairs are forwarded and where detection happens.
module tb_schmidl_cox_sync_controller;

   localparam int FFT    = 1024;
   localparam int CP     = 128;
   localparam int MW     = 32 + $clog2(CP + 1);
   localparam int SOFF   = 0;
   localparam int MAXN   = 6000;
   localparam int BUDGET = 40000;

   logic          clk = 1'b0;
   logic          reset;
   logic          clear;
   logic [MW-1:0] threshold;
   logic [7:0]    num_symbols;
   logic [MW-1:0] m_tdata;
   logic          m_tvalid, m_tready, m_tlast;
   logic [31:0]   s_tdata;
   logic          s_tvalid, s_tready, s_tlast;
   logic [31:0]   o_tdata;
   logic          o_tlast, o_tvalid, o_tready;
   logic          detect;
   logic [MW-1:0] peak_value;
   logic          busy;

   always #5 clk = ~clk;

   schmidl_cox_sync_controller #(
      .FFT_SIZE     (FFT),
      .CP_SIZE      (CP),
      .METRIC_WIDTH (MW),
      .START_OFFSET (SOFF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .threshold   (threshold),
      .num_symbols (num_symbols),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tlast     (m_tlast),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tlast     (s_tlast),
      .o_tdata     (o_tdata),
      .o_tlast     (o_tlast),
      .o_tvalid    (o_tvalid),
      .o_tready    (o_tready),
      .detect      (detect),
      .peak_value  (peak_value),
      .busy        (busy)
   );

   typedef struct {
      int idx;
      bit last;
   } out_t;

   out_t          exp_out[$];
   int            exp_det[$];
   logic [MW-1:0] exp_pk[$];
   logic [MW-1:0] metric_mem[MAXN];

   int vectors     = 0;
   int miscompares = 0;

   // Results of the most recent stream run.
   int run_fires, run_cycles, run_outs, run_dets;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Frame-level model. Detection confirms on the first pair lying CP pairs after
   // the first occurrence of the running maximum. Each symbol is FFT consecutive
   // pairs, and consecutive symbols are FFT+CP pairs apart.
   task automatic build_expect(input int n, input logic [MW-1:0] thr, input int nsym);
      int   i, best, conf, first, ns;
      out_t e;
      exp_out.delete();
      exp_det.delete();
      exp_pk.delete();
      ns = (nsym == 0) ? 1 : nsym;
      i  = 0;
      while (i < n) begin
         if (metric_mem[i] > thr) begin
            best = i;
            conf = -1;
            for (int j = i + 1; j < n; j++) begin
               if (metric_mem[j] > metric_mem[best]) best = j;
               if (j - best == CP) begin
                  conf = j;
                  break;
               end
            end
            if (conf < 0) begin
               i = n;
            end else begin
               exp_det.push_back(conf);
               exp_pk.push_back(metric_mem[best]);
               first = conf + 1 + SOFF;
               for (int s = 0; s < ns; s++) begin
                  for (int k = 0; k < FFT; k++) begin
                     e.idx  = first + s * (FFT + CP) + k;
                     e.last = (k == FFT - 1);
                     if (e.idx < n) exp_out.push_back(e);
                  end
               end
               i = first + (ns - 1) * (FFT + CP) + FFT;
            end
         end else begin
            i++;
         end
      end
   endtask

   // Streams pairs 0..n-1 (s_tdata = pair index) with the given valid/ready
   // percentages. clear_at >= 0 raises clear once that many outputs have been seen.
   task automatic run_stream(input int n, input int pv, input int pr, input int clear_at, input bit final_checks);
      int   idx;
      bit   stop;
      out_t e;
      idx        = 0;
      stop       = 1'b0;
      run_fires  = 0;
      run_cycles = 0;
      run_outs   = 0;
      run_dets   = 0;
      while (idx < n && run_cycles < BUDGET && !stop) begin
         @(negedge clk);
         m_tvalid = ($urandom_range(0, 99) < pv);
         s_tvalid = ($urandom_range(0, 99) < pv);
         m_tdata  = metric_mem[idx];
         s_tdata  = 32'(idx);
         o_tready = ($urandom_range(0, 99) < pr);
         clear    = (clear_at >= 0) && (run_outs == clear_at);
         #1;
         if (detect) begin
            run_dets++;
            if (exp_det.size() == 0) begin
               check("spurious_detect", 64'(idx - 1), 64'hFFFF_FFFF);
            end else begin
               check("detect_pair", 64'(idx - 1), 64'(exp_det.pop_front()));
               check("detect_peak", 64'(peak_value), 64'(exp_pk.pop_front()));
            end
         end
         if (o_tvalid && o_tready) begin
            if (exp_out.size() == 0) begin
               check("spurious_out", 64'(o_tdata), 64'hFFFF_FFFF);
            end else begin
               e = exp_out.pop_front();
               check("o_tdata", 64'(o_tdata), 64'(e.idx));
               check("o_tlast", 64'(o_tlast), 64'(e.last));
            end
            run_outs++;
         end
         if (m_tvalid && m_tready) begin
            idx++;
            run_fires++;
         end
         run_cycles++;
         if (clear) stop = 1'b1;
      end
      if (run_cycles >= BUDGET) check("run_timeout", 64'(run_cycles), 64'(0));
      if (final_checks) begin
         check("outputs_left", 64'(exp_out.size()), 64'd0);
         check("detects_left", 64'(exp_det.size()), 64'd0);
      end
      @(negedge clk);
      m_tvalid = 1'b0;
      s_tvalid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic fill_metric(input int n, input logic [MW-1:0] v);
      for (int i = 0; i < n; i++) metric_mem[i] = v;
   endtask

   initial begin
      int            n, p, q, nsym;
      logic [MW-1:0] v, thr;

      reset       = 1'b1;
      clear       = 1'b0;
      threshold   = MW'('h40000);
      num_symbols = 8'd2;
      m_tdata     = '0;
      m_tvalid    = 1'b0;
      m_tlast     = 1'b0;
      s_tdata     = '0;
      s_tvalid    = 1'b0;
      s_tlast     = 1'b0;
      o_tready    = 1'b1;
      #12;
      reset = 1'b0;
      #1;
      check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
      check("rst_o_tlast", 64'(o_tlast), 64'd0);
      check("rst_detect", 64'(detect), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_peak_value", 64'(peak_value), 64'd0);

      // No detection: a flat metric below threshold, one pair consumed per cycle.
      n = 5000;
      fill_metric(n, MW'('h100));
      build_expect(n, threshold, 2);
      run_stream(n, 100, 100, -1, 1'b1);
      check("nodet_consumed", 64'(run_fires), 64'd5000);
      check("nodet_cycles", 64'(run_cycles), 64'd5000);
      check("nodet_detects", 64'(run_dets), 64'd0);
      check("nodet_outputs", 64'(run_outs), 64'd0);

      // Two-symbol frame with a single peak at pair 2000.
      n = 4600;
      fill_metric(n, MW'('h100));
      metric_mem[2000] = MW'('h100000);
      num_symbols = 8'd2;
      build_expect(n, threshold, 2);
      check("frame_model_det", 64'(exp_det[0]), 64'd2128);
      run_stream(n, 100, 100, -1, 1'b1);
      check("frame_outputs", 64'(run_outs), 64'(2 * FFT));
      check("frame_peak_value", 64'(peak_value), 64'h100000);
      check("frame_busy_end", 64'(busy), 64'd0);

      // Plateau: ties hold the first maximum, so confirmation comes at pair 228.
      n = 1700;
      fill_metric(n, MW'('h100));
      for (int i = 100; i <= 400; i++) metric_mem[i] = MW'('h80000);
      num_symbols = 8'd1;
      build_expect(n, threshold, 1);
      check("plateau_model_det", 64'(exp_det[0]), 64'd228);
      run_stream(n, 100, 100, -1, 1'b1);
      check("plateau_peak_value", 64'(peak_value), 64'h80000);
      check("plateau_busy_end", 64'(busy), 64'd0);

      // The two-symbol frame again, under random valids and 50% backpressure.
      n = 4600;
      fill_metric(n, MW'('h100));
      metric_mem[2000] = MW'('h100000);
      num_symbols = 8'd2;
      build_expect(n, threshold, 2);
      run_stream(n, 75, 50, -1, 1'b1);
      check("bp_outputs", 64'(run_outs), 64'(2 * FFT));
      check("bp_busy_end", 64'(busy), 64'd0);

      // Random frames: noise at or below threshold, a main peak, and a second
      // in-window peak that may be larger, equal or smaller.
      for (int r = 0; r < 2; r++) begin
         n   = 4000;
         thr = threshold;
         for (int i = 0; i < n; i++) metric_mem[i] = MW'($urandom_range(0, 'h40000));
         p = $urandom_range(100, 600);
         v = MW'('h100000 + $urandom_range(0, 'hFFFF));
         metric_mem[p]     = v;
         metric_mem[p + 1] = '0;
         q = p + $urandom_range(2, CP - 1);
         case ($urandom_range(0, 2))
            0:       metric_mem[q] = v + MW'($urandom_range(1, 'hFFF));
            1:       metric_mem[q] = v;
            default: metric_mem[q] = v - MW'(1);
         endcase
         nsym        = $urandom_range(0, 2);
         num_symbols = 8'(nsym);
         build_expect(n, thr, nsym);
         run_stream(n, 80, 60, -1, 1'b1);
         check("rand_detects", 64'(run_dets), 64'd1);
      end

      // Clear mid-symbol: raised while output sample 500 transfers.
      n = 4600;
      fill_metric(n, MW'('h100));
      metric_mem[2000] = MW'('h100000);
      num_symbols = 8'd2;
      build_expect(n, threshold, 2);
      run_stream(n, 100, 100, 500, 1'b0);
      m_tvalid = 1'b1;
      s_tvalid = 1'b1;
      #1;
      check("clear_o_tvalid", 64'(o_tvalid), 64'd0);
      check("clear_busy", 64'(busy), 64'd0);
      check("clear_peak_hold", 64'(peak_value), 64'h100000);
      m_tvalid = 1'b0;
      s_tvalid = 1'b0;

      // After clear, a fresh stream is detected normally.
      n = 1700;
      fill_metric(n, MW'('h100));
      metric_mem[300] = MW'('h90000);
      num_symbols = 8'd1;
      build_expect(n, threshold, 1);
      run_stream(n, 100, 100, -1, 1'b1);
      check("redetect_count", 64'(run_dets), 64'd1);
      check("redetect_peak", 64'(peak_value), 64'h90000);

      // Asynchronous reset while in PEAK, between clock edges.
      n = 80;
      fill_metric(n, MW'('h100));
      metric_mem[50] = MW'('h70000);
      build_expect(n, threshold, 1);
      run_stream(n, 100, 100, -1, 1'b1);
      check("peak_busy", 64'(busy), 64'd1);
      m_tvalid = 1'b1;
      s_tvalid = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_peak_value", 64'(peak_value), 64'd0);
      check("arst_detect", 64'(detect), 64'd0);
      check("arst_o_tvalid", 64'(o_tvalid), 64'd0);
      check("arst_o_tlast", 64'(o_tlast), 64'd0);
      m_tvalid = 1'b0;
      s_tvalid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
